// File: rtl/mitll_pulse_pkg.sv
// Shared types and constants for the cycle-based RSFQ pulse cell models.
package mitll_pulse_pkg;

    // Width and saturation value of the "cycles since event" timers.
    localparam int                 TIMER_W   = 5;
    localparam logic [TIMER_W-1:0] TIMER_SAT = 5'd31;

    // Storage state of a clocked DFF cell.
    typedef enum logic {
        EMPTY  = 1'b0,
        STORED = 1'b1
    } dff_state_t;

endpackage

// File: rtl/mitll_pulse_delay_line.sv
// Reset-clearable pulse delay line: a pulse entering on din emerges on dout
// exactly DEPTH cycles later. Any pattern of pulses can be in flight at once.
// dout_next is the value dout takes on the next edge, so a consumer can react
// in the same cycle the pulse appears.
module mitll_pulse_delay_line #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic dout_next
);

    logic [DEPTH-1:0] sr_p1;

    generate
        if (DEPTH == 1) begin : g_single
            // Single-stage line: just one pulse register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr_p1 <= '0;
                else        sr_p1 <= din;
            end
            assign dout_next = din;
        end else begin : g_multi
            // Shift register, head at bit 0, tail at bit DEPTH-1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr_p1 <= '0;
                else        sr_p1 <= {sr_p1[DEPTH-2:0], din};
            end
            assign dout_next = sr_p1[DEPTH-2];
        end
    endgenerate

    assign dout = sr_p1[DEPTH-1];

endmodule

// File: rtl/mitll_dfft_pulse_sampler.sv
// Cycle-based model of a clocked RSFQ DFF stage. Stores one data pulse; each
// RSFQ clock pulse that finds data stored launches one output pulse DELAY_CQ
// cycles later. Setup, hold and double-store violations are flagged and the
// emitted output pulses are counted.
module mitll_dfft_pulse_sampler
    import mitll_pulse_pkg::*;
#(
    parameter int DELAY_CQ = 5,   // 1..31
    parameter int T_SETUP  = 3,
    parameter int T_HOLD   = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_pulse,
    input  logic             clk_pulse,
    output logic             q_pulse,
    output logic             err_setup,
    output logic             err_hold,
    output logic             err_double,
    output logic [CNT_W-1:0] pulse_count
);

    localparam logic [TIMER_W-1:0] SETUP_LIM = TIMER_W'(T_SETUP);
    localparam logic [TIMER_W-1:0] HOLD_LIM  = TIMER_W'(T_HOLD);

    // Saturating increment for the event timers.
    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
        return (v == TIMER_SAT) ? v : v + 1'b1;
    endfunction

    dff_state_t         state_p1;
    dff_state_t         state_next;
    logic               fire;
    logic               double_hit;
    logic               setup_hit;
    logic               hold_hit;
    logic               q_next;
    logic [TIMER_W-1:0] since_a;
    logic [TIMER_W-1:0] since_clk;
    logic [TIMER_W-1:0] since_a_p1;
    logic [TIMER_W-1:0] since_clk_p1;

    // Timers read 0 in the cycle of their own event, otherwise count up from
    // last cycle's value and stick at saturation.
    assign since_a   = a_pulse   ? '0 : sat_inc(since_a_p1);
    assign since_clk = clk_pulse ? '0 : sat_inc(since_clk_p1);

    // Setup: data arrived within T_SETUP cycles before the clock (same cycle excluded).
    assign setup_hit = clk_pulse && (since_a != '0) && (since_a <= SETUP_LIM);
    // Hold: data arrived in the clock cycle or within T_HOLD-1 cycles after it.
    assign hold_hit  = a_pulse && (since_clk < HOLD_LIM);

    // Next-state and launch decision; the clock always acts on the prior state,
    // and a coincident data pulse is kept for the following clock.
    always_comb begin
        state_next = state_p1;
        fire       = 1'b0;
        double_hit = 1'b0;
        if (clk_pulse && (state_p1 == STORED)) begin
            fire = 1'b1;
        end
        if (a_pulse) begin
            if ((state_p1 == STORED) && !clk_pulse) begin
                double_hit = 1'b1;
            end
            state_next = STORED;
        end else if (clk_pulse) begin
            state_next = EMPTY;
        end
    end

    // State register and error flags (setup/hold one-cycle, double sticky).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1   <= EMPTY;
            err_setup  <= 1'b0;
            err_hold   <= 1'b0;
            err_double <= 1'b0;
        end else begin
            state_p1   <= state_next;
            err_setup  <= setup_hit;
            err_hold   <= hold_hit;
            err_double <= err_double | double_hit;
        end
    end

    // Timer registers start saturated so nothing is flagged right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            since_a_p1   <= TIMER_SAT;
            since_clk_p1 <= TIMER_SAT;
        end else begin
            since_a_p1   <= since_a;
            since_clk_p1 <= since_clk;
        end
    end

    mitll_pulse_delay_line #(
        .DEPTH (DELAY_CQ)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (fire),
        .dout      (q_pulse),
        .dout_next (q_next)
    );

    // Count on the same edge that raises q_pulse, so the count already
    // includes a pulse in the cycle that pulse is visible; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pulse_count <= '0;
        else if (q_next) pulse_count <= pulse_count + 1'b1;
    end

endmodule

// File: tb/tb_mitll_dfft_pulse_sampler.sv
module tb_mitll_dfft_pulse_sampler;

    logic        clk;
    logic        rst_n;
    logic        a_pulse;
    logic        clk_pulse;
    logic        q_pulse;
    logic        err_setup;
    logic        err_hold;
    logic        err_double;
    logic [15:0] pulse_count;

    logic        w_q;
    logic        w_s;
    logic        w_h;
    logic        w_d;
    logic [1:0]  w_count;

    mitll_dfft_pulse_sampler #(
        .DELAY_CQ (5),
        .T_SETUP  (3),
        .T_HOLD   (2),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_pulse     (a_pulse),
        .clk_pulse   (clk_pulse),
        .q_pulse     (q_pulse),
        .err_setup   (err_setup),
        .err_hold    (err_hold),
        .err_double  (err_double),
        .pulse_count (pulse_count)
    );

    mitll_dfft_pulse_sampler #(
        .DELAY_CQ (5),
        .T_SETUP  (3),
        .T_HOLD   (2),
        .CNT_W    (2)
    ) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_pulse     (a_pulse),
        .clk_pulse   (clk_pulse),
        .q_pulse     (w_q),
        .err_setup   (w_s),
        .err_hold    (w_h),
        .err_double  (w_d),
        .pulse_count (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           t;
    int           n_cmp;
    int           n_bad;
    logic [255:0] q_hist, s_hist, h_hist;
    logic [255:0] q_exp, s_exp, h_exp;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic record();
        if (t < 256) begin
            q_hist[t] = q_pulse;
            s_hist[t] = err_setup;
            h_hist[t] = err_hold;
        end
    endtask

    // Drive inputs for cycle t, advance one clock, sample 1 unit after the edge.
    task automatic tick(input logic a, input logic c);
        a_pulse   = a;
        clk_pulse = c;
        @(posedge clk);
        #1;
        a_pulse   = 1'b0;
        clk_pulse = 1'b0;
        t++;
        record();
    endtask

    task automatic idle_to(input int target);
        while (t < target) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        a_pulse   = 1'b0;
        clk_pulse = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("reset_outputs", {q_pulse, err_setup, err_hold, err_double, pulse_count}, '0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        t      = 0;
        q_hist = '0; s_hist = '0; h_hist = '0;
        q_exp  = '0; s_exp  = '0; h_exp  = '0;
        record();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        t         = 0;
        rst_n     = 1'b0;
        a_pulse   = 1'b0;
        clk_pulse = 1'b0;
        @(posedge clk);
        #1;

        // Tie-off: a_pulse held low, clock every 10 cycles.
        do_reset();
        for (int i = 0; i < 200; i++) tick(1'b0, (i % 10) == 0);
        check("tieoff_q", q_hist, '0);
        check("tieoff_setup", s_hist, '0);
        check("tieoff_hold", h_hist, '0);
        check("tieoff_double", err_double, 1'b0);
        check("tieoff_count", pulse_count, 16'd0);

        // Basic capture: a@10, clk@20 -> q@25.
        do_reset();
        idle_to(10); tick(1'b1, 1'b0);
        idle_to(20); tick(1'b0, 1'b1);
        idle_to(24);
        check("basic_count_before", pulse_count, 16'd0);
        tick(1'b0, 1'b0);
        check("basic_count_at_q", pulse_count, 16'd1);
        idle_to(40);
        q_exp[25] = 1'b1;
        check("basic_q", q_hist, q_exp);
        check("basic_setup", s_hist, s_exp);
        check("basic_hold", h_hist, h_exp);
        check("basic_count", pulse_count, 16'd1);

        // Setup violation: a@18, clk@20 -> err_setup@21, q@25.
        do_reset();
        idle_to(18); tick(1'b1, 1'b0);
        idle_to(20); tick(1'b0, 1'b1);
        idle_to(40);
        q_exp[25] = 1'b1;
        s_exp[21] = 1'b1;
        check("setup_q", q_hist, q_exp);
        check("setup_flag", s_hist, s_exp);
        check("setup_hold", h_hist, h_exp);

        // Simultaneous a and clk while STORED: q@35, hold@31, stays STORED (clk@40 -> q@45).
        do_reset();
        idle_to(10); tick(1'b1, 1'b0);
        idle_to(30); tick(1'b1, 1'b1);
        idle_to(40); tick(1'b0, 1'b1);
        idle_to(60);
        q_exp[35] = 1'b1;
        q_exp[45] = 1'b1;
        h_exp[31] = 1'b1;
        check("simul_q", q_hist, q_exp);
        check("simul_hold", h_hist, h_exp);
        check("simul_setup", s_hist, s_exp);
        check("simul_double", err_double, 1'b0);
        check("simul_count", pulse_count, 16'd2);

        // Hold alone: clk@30 (EMPTY), a@31 -> hold@32; data kept for clk@50 -> q@55.
        do_reset();
        idle_to(30); tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        idle_to(50); tick(1'b0, 1'b1);
        idle_to(60);
        h_exp[32] = 1'b1;
        q_exp[55] = 1'b1;
        check("hold_flag", h_hist, h_exp);
        check("hold_q", q_hist, q_exp);
        check("hold_setup", s_hist, s_exp);

        // Double store and pipelined pulses.
        do_reset();
        idle_to(5); tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("double_set", err_double, 1'b1);
        idle_to(10); tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        idle_to(30);
        q_exp[15] = 1'b1;
        q_exp[17] = 1'b1;
        s_exp[11] = 1'b1;
        s_exp[13] = 1'b1;
        h_exp[12] = 1'b1;
        check("pipe_q", q_hist, q_exp);
        check("pipe_setup", s_hist, s_exp);
        check("pipe_hold", h_hist, h_exp);
        check("double_sticky", err_double, 1'b1);
        check("pipe_count", pulse_count, 16'd2);

        // Reset mid-flight: prior pulse q@13, then clk@20 while STORED, reset during 22..23.
        do_reset();
        idle_to(2);  tick(1'b1, 1'b0);
        idle_to(8);  tick(1'b0, 1'b1);
        idle_to(14); tick(1'b1, 1'b0);
        idle_to(20); tick(1'b0, 1'b1);
        idle_to(22);
        check("midrst_count_before", pulse_count, 16'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {q_pulse, err_setup, err_hold, err_double, pulse_count}, '0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        idle_to(40); tick(1'b0, 1'b1);
        idle_to(60);
        q_exp[13] = 1'b1;
        check("midrst_q", q_hist, q_exp);
        check("midrst_count_after", pulse_count, 16'd0);
        check("midrst_flags", {err_setup, err_hold, err_double}, 3'b000);

        // Counter wrap with CNT_W=2: four pulses at q@11,21,31,41.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle_to(10 * k + 1); tick(1'b1, 1'b0);
            idle_to(10 * k + 6); tick(1'b0, 1'b1);
        end
        idle_to(31);
        check("wrap_count_3", w_count, 2'd3);
        tick(1'b1, 1'b0);
        idle_to(36); tick(1'b0, 1'b1);
        idle_to(50);
        q_exp[11] = 1'b1;
        q_exp[21] = 1'b1;
        q_exp[31] = 1'b1;
        q_exp[41] = 1'b1;
        check("wrap_q", q_hist, q_exp);
        check("wrap_count_0", w_count, 2'd0);
        check("wrap_main_count", pulse_count, 16'd4);
        check("wrap_side_outputs", {w_q, w_s, w_h, w_d}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
